cselsubseq: RTL and testbench



---
 rtl/cselsub_pkg.sv | 20 ++
 rtl/cselsub_nib.sv | 32 +++
 rtl/cselsubseq.sv | 157 +++++++++++++++
 tb/tb_cselsubseq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cselsub_pkg.sv
// cselsub_pkg
//   Shared definitions for the sequential borrow-select subtractor.
//   NIB_W     : width of the nibble slice processed per clock
//   state_t   : controller states (IDLE, RUN, DONE)
//   nib_count : number of nibbles needed to cover an operand of a given width
package cselsub_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nib_count(input int width);
      return width / NIB_W;
   endfunction

endpackage

// File: rtl/cselsub_nib.sv
// cselsub_nib
//   Combinational 4-bit borrow-select subtract slice.
//   Both borrow variants are formed side by side, and bin only drives the
//   final 2:1 select.
//   Ports:
//     a, b  in  NIB_W  minuend / subtrahend nibble
//     bin   in  1      borrow into this nibble
//     diff  out NIB_W  selected difference nibble
//     bout  out 1      selected borrow out of this nibble
module cselsub_nib
   import cselsub_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             bin,
   output logic [NIB_W-1:0] diff,
   output logic             bout
);

   // The extra MSB of each 5-bit result is the borrow. The borrow-1 variant
   // is written as a + {1,~b} (== a - b - 1 mod 32), so it does not have to
   // wait for the borrow-0 result.
   logic [NIB_W:0] t0;
   logic [NIB_W:0] t1;

   assign t0 = {1'b0, a} - {1'b0, b};
   assign t1 = {1'b0, a} + {1'b1, ~b};

   assign diff = bin ? t1[NIB_W-1:0] : t0[NIB_W-1:0];
   assign bout = bin ? t1[NIB_W]     : t0[NIB_W];

endmodule

// File: rtl/cselsubseq.sv
// cselsubseq
//   Sequential borrow-select subtractor. It computes (a - b - bin) mod
//   2^WIDTH one nibble per clock, least-significant nibble first, through a
//   single time-multiplexed cselsub_nib slice.
//
//   Handshake: start is sampled only in IDLE or DONE. An accepted start
//   latches a, b and bin, and busy is high for the next WIDTH/4 cycles.
//   done then pulses for exactly one cycle, and diff/bout/zero update in that
//   same cycle. start during busy is ignored. busy and done are decoded from
//   the state register, so neither has a combinational path from start.
//
//   Ports:
//     clk, rst_n  clock; asynchronous active-low reset
//     start       operation request
//     a, b, bin   operands and borrow-in (latched on acceptance)
//     busy        nibbles being processed
//     done        one-cycle completion pulse
//     diff        difference, held until the next completion
//     bout        borrow out (a < b + bin, unsigned)
//     zero        diff == 0, registered with diff
//     state_dbg   current controller state (state_t encoding)
module cselsubseq
   import cselsub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic [1:0]       state_dbg
);

   localparam int N     = nib_count(WIDTH);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   generate
      if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
         $error("cselsubseq: WIDTH must be a multiple of 4 and at least 4");
      end
   endgenerate

   state_t state;
   state_t state_nx;
   logic   accept;

   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_nx;
   logic [IDX_W-1:0] idx;
   logic             brw;

   logic [NIB_W-1:0] nib_a;
   logic [NIB_W-1:0] nib_b;
   logic [NIB_W-1:0] nib_d;
   logic             nib_bo;

   // Operand nibble selection and working-result merge for the current index
   always_comb begin
      nib_a   = opa[NIB_W*idx +: NIB_W];
      nib_b   = opb[NIB_W*idx +: NIB_W];
      work_nx = work;
      work_nx[NIB_W*idx +: NIB_W] = nib_d;
   end

   cselsub_nib u_nib (
      .a    (nib_a),
      .b    (nib_b),
      .bin  (brw),
      .diff (nib_d),
      .bout (nib_bo)
   );

   // Next-state logic
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (idx == LAST) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign state_dbg = state;

   // Datapath: operands are loaded only on acceptance, so input changes and
   // starts seen during RUN cannot disturb the operation in flight. The
   // visible result is loaded only from the final nibble, so partial
   // results are never shown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa  <= '0;
         opb  <= '0;
         work <= '0;
         idx  <= '0;
         brw  <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
         zero <= 1'b0;
      end else if (accept) begin
         opa  <= a;
         opb  <= b;
         brw  <= bin;
         idx  <= '0;
         work <= '0;
      end else if (state == RUN) begin
         work <= work_nx;
         brw  <= nib_bo;
         if (idx == LAST) begin
            idx  <= '0;
            diff <= work_nx;
            bout <= nib_bo;
            zero <= (work_nx == '0);
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cselsubseq.sv
module tb_cselsubseq;

   localparam int W = 16;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         bin   = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         zero;
   logic [1:0]   state_dbg;

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt    = 0;

   // expected results, packed as {diff, bout, zero}
   logic [W+1:0] exp_q[$];
   logic [W+1:0] cur = '0;

   cselsubseq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .busy      (busy),
      .done      (done),
      .diff      (diff),
      .bout      (bout),
      .zero      (zero),
      .state_dbg (state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   // reference model: plain integer arithmetic on the whole operand
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic bi);
      longint       d;
      logic [W-1:0] dd;
      logic         bo;
      d  = longint'(x) - longint'(y) - longint'(bi);
      bo = (d < 0);
      if (d < 0) d = d + (longint'(1) << W);
      dd = d[W-1:0];
      return {dd, bo, (dd == '0)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // scoreboard / compare process: outputs must always equal the most recent
   // completed result, and each done pulse retires one expected entry
   always @(negedge clk) begin
      if (!rst_n) begin
         cur = '0;
         exp_q.delete();
      end else begin
         if (busy && done) chk("busy_and_done", 32'd1, 32'd0);
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
            else cur = exp_q.pop_front();
         end
         chk("sb_diff", 32'(diff), 32'(cur[W+1:2]));
         chk("sb_bout", 32'(bout), 32'(cur[1]));
         chk("sb_zero", 32'(zero), 32'(cur[0]));
      end
   end

   // driver tasks
   task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
      a     = x;
      b     = y;
      bin   = bi;
      start = 1'b1;
      exp_q.push_back(model(x, y, bi));
   endtask

   // Called just after an edge, with the DUT in RUN cycle c0. Returns the
   // cycle number in which done is seen (sampling is at the negedge).
   task automatic wait_done(input int c0, output int cyc);
      cyc = 0;
      for (int c = c0; c <= 30; c++) begin
         @(negedge clk);
         if (done) begin
            cyc = c;
            break;
         end
         chk("busy_during_run", 32'(busy), 32'd1);
         @(posedge clk); #1;
      end
      if (cyc == 0) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_to_done(input string nm, input logic [W-1:0] ld, input logic lb,
                              input logic lz);
      int cyc;
      @(posedge clk); #1;
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom_range(0, 1));
      wait_done(1, cyc);
      chk({nm, "_latency"}, 32'(cyc), 32'd5);
      chk({nm, "_diff"}, 32'(diff), 32'(ld));
      chk({nm, "_bout"}, 32'(bout), 32'(lb));
      chk({nm, "_zero"}, 32'(zero), 32'(lz));
   endtask

   initial begin
      int cyc;
      int dc0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_bout", 32'(bout), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'd0);
      rst_n = 1'b1;

      // hand-computed values pinning the model
      chk("model_a", 32'(model(16'h1234, 16'h0234, 1'b0)), 32'({16'h1000, 1'b0, 1'b0}));
      chk("model_b", 32'(model(16'h0000, 16'h0001, 1'b0)), 32'({16'hFFFF, 1'b1, 1'b0}));
      chk("model_c", 32'(model(16'h5555, 16'h5554, 1'b1)), 32'({16'h0000, 1'b0, 1'b1}));
      chk("model_d", 32'(model(16'hFFFF, 16'hFFFF, 1'b1)), 32'({16'hFFFF, 1'b1, 1'b0}));

      // basic operations
      @(posedge clk); #1;
      start_op(16'h1234, 16'h0234, 1'b0);
      run_to_done("op1234", 16'h1000, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("idle_after_done", 32'(state_dbg), 32'd0);

      start_op(16'h0000, 16'h0001, 1'b0);
      run_to_done("ripple", 16'hFFFF, 1'b1, 1'b0);
      @(posedge clk); #1;

      start_op(16'h5555, 16'h5554, 1'b1);
      run_to_done("zero", 16'h0000, 1'b0, 1'b1);
      @(posedge clk); #1;

      // start held high: second operation accepted in DONE
      start_op(16'hFFFF, 16'hFFFF, 1'b1);
      @(posedge clk); #1;
      a = 16'hAAAA;
      b = 16'h1111;
      wait_done(1, cyc);
      chk("held1_latency", 32'(cyc), 32'd5);
      chk("held1_diff", 32'(diff), 32'h0000FFFF);
      chk("held1_bout", 32'(bout), 32'd1);
      start_op(16'h0010, 16'h0001, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1, cyc);
      chk("held2_latency", 32'(cyc), 32'd5);
      chk("held2_diff", 32'(diff), 32'h0000000F);
      chk("held2_bout", 32'(bout), 32'd0);
      @(posedge clk); #1;

      // start re-pulsed mid-RUN with other operands: ignored
      dc0 = done_cnt;
      start_op(16'h0F0F, 16'h0101, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      a     = 16'hFFFF;
      b     = 16'h0000;
      bin   = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(3, cyc);
      chk("restart_latency", 32'(cyc), 32'd5);
      chk("restart_diff", 32'(diff), 32'h00000E0E);
      repeat (8) @(posedge clk);
      #1;
      chk("restart_one_done", 32'(done_cnt - dc0), 32'd1);

      // asynchronous reset during RUN cycle 2
      start_op(16'h1234, 16'h0001, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_diff", 32'(diff), 32'd0);
      chk("arst_bout", 32'(bout), 32'd0);
      chk("arst_zero", 32'(zero), 32'd0);
      chk("arst_state", 32'(state_dbg), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      start_op(16'h0100, 16'h0001, 1'b0);
      run_to_done("post_rst", 16'h00FF, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // global watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
